// File: rtl/pc_unit_if.sv
// pc_unit_if: control-side requests and fetch-address outputs of the program-counter unit.
interface pc_unit_if #(
  parameter int ADDR_W = 32,
  parameter int RAS_AW = 2
);
  logic              pc_ena;
  logic              exc_req;
  logic              eret_req;
  logic              jmp_ret;
  logic              jmp_call;
  logic              br_taken;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] pc_out;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] epc_out;
  logic              in_exc;
  logic [RAS_AW:0]   ras_count;
  logic              ras_ovf;
  logic              ras_udf;
  modport master (
    output pc_ena, exc_req, eret_req, jmp_ret, jmp_call, br_taken, jmp_target, br_target,
    input  pc_out, pc_plus4, epc_out, in_exc, ras_count, ras_ovf, ras_udf
  );
  modport slave (
    input  pc_ena, exc_req, eret_req, jmp_ret, jmp_call, br_taken, jmp_target, br_target,
    output pc_out, pc_plus4, epc_out, in_exc, ras_count, ras_ovf, ras_udf
  );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: prioritised next-fetch-address register with return-address stack and exception PC.
module pc_unit #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] PC_START  = 32'h0040_0000,
  parameter logic [ADDR_W-1:0] EXC_VEC   = 32'h0040_0004,
  parameter int                RAS_DEPTH = 4,
  parameter int                RAS_AW    = 2
) (
  input logic       pc_clock,
  input logic       rst,
  pc_unit_if.slave  bus
);
  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);
  localparam logic [RAS_AW:0]   FULL  = (RAS_AW+1)'(RAS_DEPTH);
  logic [ADDR_W-1:0] ras [RAS_DEPTH];
  logic [RAS_AW-1:0] ptr;
  logic [RAS_AW-1:0] ptr_nxt;
  logic              take_exc;
  logic              take_eret;
  logic              empty;
  logic              full;
  assign take_exc     = bus.exc_req && !bus.in_exc;
  assign take_eret    = bus.eret_req && bus.in_exc;
  assign empty        = bus.ras_count == '0;
  assign full         = bus.ras_count == FULL;
  assign ptr_nxt      = ptr + RAS_AW'(1);
  assign bus.pc_plus4 = bus.pc_out + ADDR_W'(4);
  // Each branch of the chain is one priority level; lower requests in the same cycle have no effect.
  always_ff @(posedge pc_clock) begin
    if (rst) begin
      bus.pc_out    <= PC_START;
      bus.epc_out   <= '0;
      bus.in_exc    <= 1'b0;
      bus.ras_count <= '0;
      bus.ras_ovf   <= 1'b0;
      bus.ras_udf   <= 1'b0;
      ptr           <= '0;
    end else if (bus.pc_ena) begin
      if (take_exc) begin
        bus.epc_out <= bus.pc_out;
        bus.pc_out  <= EXC_VEC & ALIGN;
        bus.in_exc  <= 1'b1;
      end else if (take_eret) begin
        bus.pc_out <= bus.epc_out & ALIGN;
        bus.in_exc <= 1'b0;
      end else if (bus.jmp_ret) begin
        if (empty) begin
          bus.pc_out  <= bus.jmp_target & ALIGN;
          bus.ras_udf <= 1'b1;
        end else begin
          bus.pc_out    <= ras[ptr] & ALIGN;
          ptr           <= ptr - RAS_AW'(1);
          bus.ras_count <= bus.ras_count - (RAS_AW+1)'(1);
        end
      end else if (bus.jmp_call) begin
        ras[ptr_nxt]  <= bus.pc_plus4;
        ptr           <= ptr_nxt;
        bus.pc_out    <= bus.jmp_target & ALIGN;
        bus.ras_count <= full ? bus.ras_count : bus.ras_count + (RAS_AW+1)'(1);
        bus.ras_ovf   <= bus.ras_ovf | full;
      end else begin
        bus.pc_out <= bus.br_taken ? (bus.br_target & ALIGN) : bus.pc_plus4;
      end
    end
  end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table, randomized run against a queue-based model, and 8-bit wrap check.
module tb_pc_unit;
  localparam logic [31:0] START = 32'h0040_0000;
  localparam logic [31:0] EXCV  = 32'h0040_0004;
  localparam int          DEPTH = 4;
  typedef struct {
    logic        rst, ena, exc, eret, ret, call, br;
    logic [31:0] jt, bt, exp_pc;
    int          exp_cnt;
  } vec_t;
  logic pc_clock = 1'b0;
  logic rst = 1'b1;
  logic rst8 = 1'b1;
  int total = 0;
  int bad = 0;
  logic [31:0] m_pc, m_epc;
  logic        m_exc, m_ovf, m_udf;
  logic [31:0] m_ras [$];
  vec_t tbl [$];
  pc_unit_if #(.ADDR_W(32), .RAS_AW(2)) bus ();
  pc_unit_if #(.ADDR_W(8), .RAS_AW(2)) bus8 ();
  pc_unit #(.ADDR_W(32), .PC_START(START), .EXC_VEC(EXCV), .RAS_DEPTH(4), .RAS_AW(2))
    dut (.pc_clock(pc_clock), .rst(rst), .bus(bus));
  pc_unit #(.ADDR_W(8), .PC_START(8'hF0), .EXC_VEC(8'h04), .RAS_DEPTH(4), .RAS_AW(2))
    dut8 (.pc_clock(pc_clock), .rst(rst8), .bus(bus8));
  always #5 pc_clock = ~pc_clock;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", n, a, e);
    end
  endtask
  function automatic vec_t mk(input logic r, e, x, er, rt, c, b,
                              input logic [31:0] jt, bt, pc, input int cnt);
    vec_t v;
    v.rst = r; v.ena = e; v.exc = x; v.eret = er; v.ret = rt; v.call = c; v.br = b;
    v.jt = jt; v.bt = bt; v.exp_pc = pc; v.exp_cnt = cnt;
    return v;
  endfunction
  // Reference: RAS as an unbounded queue trimmed from the oldest end.
  task automatic model(input vec_t v);
    if (v.rst) begin
      m_pc = START; m_epc = 0; m_exc = 0; m_ovf = 0; m_udf = 0;
      m_ras.delete();
    end else if (v.ena) begin
      if (v.exc && !m_exc) begin
        m_epc = m_pc; m_pc = EXCV; m_exc = 1;
      end else if (v.eret && m_exc) begin
        m_pc = m_epc; m_exc = 0;
      end else if (v.ret) begin
        if (m_ras.size() > 0) m_pc = m_ras.pop_back() & ~32'd3;
        else begin m_pc = v.jt & ~32'd3; m_udf = 1; end
      end else if (v.call) begin
        m_ras.push_back(m_pc + 32'd4);
        if (m_ras.size() > DEPTH) begin void'(m_ras.pop_front()); m_ovf = 1; end
        m_pc = v.jt & ~32'd3;
      end else if (v.br) m_pc = v.bt & ~32'd3;
      else m_pc = m_pc + 32'd4;
    end
  endtask
  task automatic apply(input vec_t v);
    rst = v.rst;
    bus.pc_ena = v.ena; bus.exc_req = v.exc; bus.eret_req = v.eret;
    bus.jmp_ret = v.ret; bus.jmp_call = v.call; bus.br_taken = v.br;
    bus.jmp_target = v.jt; bus.br_target = v.bt;
    model(v);
    @(posedge pc_clock); #1;
    chk("pc", bus.pc_out, m_pc);
    chk("pc_plus4", bus.pc_plus4, m_pc + 32'd4);
    chk("epc", bus.epc_out, m_epc);
    chk("in_exc", 32'(bus.in_exc), 32'(m_exc));
    chk("ras_count", 32'(bus.ras_count), 32'(m_ras.size()));
    chk("ras_ovf", 32'(bus.ras_ovf), 32'(m_ovf));
    chk("ras_udf", 32'(bus.ras_udf), 32'(m_udf));
  endtask
  initial begin
    vec_t v;
    bus.pc_ena = 0; bus.exc_req = 0; bus.eret_req = 0; bus.jmp_ret = 0; bus.jmp_call = 0;
    bus.br_taken = 0; bus.jmp_target = 0; bus.br_target = 0;
    bus8.pc_ena = 0; bus8.exc_req = 0; bus8.eret_req = 0; bus8.jmp_ret = 0; bus8.jmp_call = 0;
    bus8.br_taken = 0; bus8.jmp_target = 0; bus8.br_target = 0;
    //             rst ena exc ert ret cal br  jt            bt            exp_pc       cnt
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h00400000, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h00400004, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h00400008, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0040000C, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h00400500, 32'h0040000C, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0, 1, 1, 32'h00400700, 32'h00400500, 32'h0040000C, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h00400010, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h00400100, 32'h0,        32'h00400100, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h00400104, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h00400108, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 32'h00400900, 32'h0,        32'h00400014, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32'h0,        32'h00400033, 32'h00400030, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h00400100, 32'h0,        32'h00400100, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h00400110, 32'h0,        32'h00400110, 2));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h00400120, 32'h0,        32'h00400120, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h00400130, 32'h0,        32'h00400130, 4));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h00400140, 32'h0,        32'h00400140, 4));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 32'h00400200, 32'h0,        32'h00400134, 3));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 32'h00400200, 32'h0,        32'h00400124, 2));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 32'h00400200, 32'h0,        32'h00400114, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 32'h00400200, 32'h0,        32'h00400104, 0));
    tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 32'h00400200, 32'h0,        32'h00400200, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 1, 32'h0,        32'h00400020, 32'h00400020, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h0,        32'h00400500, 32'h00400004, 0));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h00400008, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h00400020, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h00400300, 32'h0,        32'h00400300, 1));
    tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 32'h00400400, 32'h0,        32'h00400024, 0));
    tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 32'h0,        32'h0,        32'h00400028, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h00400102, 32'h0,        32'h00400100, 1));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 0, 32'h00400203, 32'h0,        32'h00400200, 2));
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h0,        32'h0,        32'h00400004, 2));
    tbl.push_back(mk(1, 1, 1, 1, 1, 1, 1, 32'h00400700, 32'h00400500, 32'h00400000, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i]);
      chk($sformatf("tbl%0d_pc", i), bus.pc_out, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.ras_count), 32'(tbl[i].exp_cnt));
    end
    for (int i = 0; i < 400; i++) begin
      v.rst  = ($urandom % 64) == 0;
      v.ena  = ($urandom % 8) != 0;
      v.exc  = ($urandom % 8) == 0;
      v.eret = ($urandom % 6) == 0;
      v.ret  = ($urandom % 5) == 0;
      v.call = ($urandom % 4) == 0;
      v.br   = ($urandom % 4) == 0;
      v.jt = $urandom; v.bt = $urandom; v.exp_pc = 0; v.exp_cnt = 0;
      apply(v);
    end
    rst8 = 1; @(posedge pc_clock); #1;
    chk("w8_reset", 32'(bus8.pc_out), 32'h000000F0);
    rst8 = 0; bus8.pc_ena = 1;
    repeat (3) @(posedge pc_clock); #1;
    chk("w8_fc", 32'(bus8.pc_out), 32'h000000FC);
    chk("w8_plus4", 32'(bus8.pc_plus4), 32'h00000000);
    @(posedge pc_clock); #1;
    chk("w8_wrap", 32'(bus8.pc_out), 32'h00000000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
